the_data_memory: RTL and testbench

THE_DATA_MEMORY -- requirements
Module: the_data_memory

---
 rtl/the_data_memory.sv | 51 +++++
 tb/tb_the_data_memory.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/the_data_memory.sv
// Four-read, four-write register-file style data memory with asynchronous reads.
// On a same-edge address collision the highest-numbered write port wins.
module the_data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] data_rd1,
  input  logic [ADDR_WIDTH-1:0] data_rd2,
  input  logic [ADDR_WIDTH-1:0] data_rd3,
  input  logic [ADDR_WIDTH-1:0] data_rd4,
  input  logic [ADDR_WIDTH-1:0] data_wr1,
  input  logic [ADDR_WIDTH-1:0] data_wr2,
  input  logic [ADDR_WIDTH-1:0] data_wr3,
  input  logic [ADDR_WIDTH-1:0] data_wr4,
  input  logic [DATA_WIDTH-1:0] data_wr1_data,
  input  logic [DATA_WIDTH-1:0] data_wr2_data,
  input  logic [DATA_WIDTH-1:0] data_wr3_data,
  input  logic [DATA_WIDTH-1:0] data_wr4_data,
  input  logic                  data_wr1_enable,
  input  logic                  data_wr2_enable,
  input  logic                  data_wr3_enable,
  input  logic                  data_wr4_enable,
  output logic [DATA_WIDTH-1:0] data_rd1_out,
  output logic [DATA_WIDTH-1:0] data_rd2_out,
  output logic [DATA_WIDTH-1:0] data_rd3_out,
  output logic [DATA_WIDTH-1:0] data_rd4_out
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Later assignments override earlier ones, giving port 4 the highest priority.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem <= '{default: '0};
    end else begin
      if (data_wr1_enable) mem[data_wr1] <= data_wr1_data;
      if (data_wr2_enable) mem[data_wr2] <= data_wr2_data;
      if (data_wr3_enable) mem[data_wr3] <= data_wr3_data;
      if (data_wr4_enable) mem[data_wr4] <= data_wr4_data;
    end
  end

  assign data_rd1_out = mem[data_rd1];
  assign data_rd2_out = mem[data_rd2];
  assign data_rd3_out = mem[data_rd3];
  assign data_rd4_out = mem[data_rd4];

endmodule

// File: tb/tb_the_data_memory.sv
// Scoreboard bench for the_data_memory: expected read values are queued when
// stimulus is driven and popped against the combinational read outputs.
module tb_the_data_memory;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int DEPTH = 512;

  typedef struct {
    string         tag;
    int            port;
    logic [DW-1:0] value;
  } sb_entry_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] rd_addr [4];
  logic [AW-1:0] wr_addr [4];
  logic [DW-1:0] wr_data [4];
  logic          wr_en   [4];
  logic [DW-1:0] rd_out  [4];

  sb_entry_t     scoreboard [$];
  logic [DW-1:0] model [DEPTH];
  int            tests_run = 0;
  int            tests_failed = 0;

  always #5 clock = ~clock;

  the_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .data_rd1        (rd_addr[0]),
    .data_rd2        (rd_addr[1]),
    .data_rd3        (rd_addr[2]),
    .data_rd4        (rd_addr[3]),
    .data_wr1        (wr_addr[0]),
    .data_wr2        (wr_addr[1]),
    .data_wr3        (wr_addr[2]),
    .data_wr4        (wr_addr[3]),
    .data_wr1_data   (wr_data[0]),
    .data_wr2_data   (wr_data[1]),
    .data_wr3_data   (wr_data[2]),
    .data_wr4_data   (wr_data[3]),
    .data_wr1_enable (wr_en[0]),
    .data_wr2_enable (wr_en[1]),
    .data_wr3_enable (wr_en[2]),
    .data_wr4_enable (wr_en[3]),
    .data_rd1_out    (rd_out[0]),
    .data_rd2_out    (rd_out[1]),
    .data_rd3_out    (rd_out[2]),
    .data_rd4_out    (rd_out[3])
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic driveReads(input int a0, input int a1, input int a2, input int a3);
    rd_addr[0] = AW'(a0);
    rd_addr[1] = AW'(a1);
    rd_addr[2] = AW'(a2);
    rd_addr[3] = AW'(a3);
  endtask

  task automatic driveWrite(input int port, input int addr, input logic [DW-1:0] data,
                            input logic en);
    wr_addr[port] = AW'(addr);
    wr_data[port] = data;
    wr_en[port]   = en;
  endtask

  task automatic clearWrites();
    for (int p = 0; p < 4; p++) driveWrite(p, 0, '0, 1'b0);
  endtask

  task automatic expectRead(input string tag, input int port, input logic [DW-1:0] value);
    sb_entry_t e;
    e.tag = tag;
    e.port = port;
    e.value = value;
    scoreboard.push_back(e);
  endtask

  // Let the combinational read paths settle, then drain every queued expectation.
  task automatic drainScoreboard();
    sb_entry_t e;
    #1;
    while (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checkOutput($sformatf("%s.rd%0d", e.tag, e.port + 1), rd_out[e.port], e.value);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    driveReads(0, 0, 0, 0);
    clearWrites();
    driveWrite(0, 7, 32'hFFFF_FFFF, 1'b1);
    applyStimulus();
    reset = 1'b1;
    clearWrites();

    begin
      int addrs [4] = '{0, 1, 255, 511};
      foreach (addrs[i]) begin
        driveReads(addrs[i], addrs[i], addrs[i], addrs[i]);
        for (int p = 0; p < 4; p++) expectRead($sformatf("reset_a%0d", addrs[i]), p, '0);
        drainScoreboard();
      end
      driveReads(7, 7, 7, 7);
      expectRead("reset_beats_write", 0, '0);
      drainScoreboard();
    end

    driveWrite(0, 5, 32'hDEAD_BEEF, 1'b1);
    applyStimulus();
    clearWrites();
    driveReads(5, 6, 5, 5);
    expectRead("wr_rd", 0, 32'hDEAD_BEEF);
    expectRead("wr_rd", 1, 32'h0);
    expectRead("shared_rd", 2, 32'hDEAD_BEEF);
    expectRead("shared_rd", 3, 32'hDEAD_BEEF);
    drainScoreboard();

    for (int p = 0; p < 4; p++) driveWrite(p, 10 + p, DW'(p + 1), 1'b1);
    applyStimulus();
    clearWrites();
    driveReads(10, 11, 12, 13);
    for (int p = 0; p < 4; p++) expectRead("par_wr", p, DW'(p + 1));
    drainScoreboard();

    driveWrite(0, 20, 32'hAAAA_0000, 1'b1);
    driveWrite(3, 20, 32'h0000_BBBB, 1'b1);
    applyStimulus();
    clearWrites();
    driveReads(20, 20, 20, 20);
    for (int p = 0; p < 4; p++) expectRead("coll_1v4", p, 32'h0000_BBBB);
    drainScoreboard();

    driveWrite(0, 20, 32'hAAAA_0000, 1'b1);
    driveWrite(1, 20, 32'h1234_5678, 1'b1);
    driveWrite(2, 20, 32'h5555_5555, 1'b0);
    driveWrite(3, 20, 32'h6666_6666, 1'b0);
    applyStimulus();
    clearWrites();
    expectRead("coll_1v2", 0, 32'h1234_5678);
    drainScoreboard();

    driveWrite(2, 21, 32'h0000_0033, 1'b1);
    driveWrite(1, 21, 32'h0000_0022, 1'b1);
    applyStimulus();
    clearWrites();
    driveReads(21, 21, 21, 21);
    expectRead("coll_2v3", 1, 32'h0000_0033);
    drainScoreboard();

    driveWrite(1, 30, 32'h11, 1'b1);
    applyStimulus();
    clearWrites();
    driveReads(30, 0, 0, 0);
    driveWrite(2, 30, 32'h22, 1'b1);
    expectRead("rdw_before", 0, 32'h11);
    drainScoreboard();
    applyStimulus();
    clearWrites();
    expectRead("rdw_after", 0, 32'h22);
    drainScoreboard();
    for (int p = 0; p < 4; p++) driveWrite(p, 30, 32'h99, 1'b0);
    applyStimulus();
    clearWrites();
    expectRead("wr_disabled", 0, 32'h22);
    drainScoreboard();

    reset = 1'b0;
    driveWrite(0, 40, 32'h5, 1'b1);
    driveReads(30, 5, 10, 40);
    expectRead("reset_no_async", 0, 32'h22);
    expectRead("reset_no_async", 1, 32'hDEAD_BEEF);
    drainScoreboard();
    applyStimulus();
    reset = 1'b1;
    clearWrites();
    for (int p = 0; p < 4; p++) expectRead("reset_clears", p, '0);
    drainScoreboard();
    driveReads(20, 11, 13, 21);
    for (int p = 0; p < 4; p++) expectRead("reset_clears2", p, '0);
    drainScoreboard();

    // Random writes over a tiny address window to provoke collisions.
    foreach (model[i]) model[i] = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      for (int p = 0; p < 4; p++)
        driveWrite(p, $urandom_range(0, 7), DW'($urandom), 1'($urandom_range(0, 1)));
      for (int p = 0; p < 4; p++)
        if (wr_en[p]) model[wr_addr[p]] = wr_data[p];
      applyStimulus();
      clearWrites();
      driveReads($urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7));
      for (int p = 0; p < 4; p++) expectRead($sformatf("rand%0d", cyc), p, model[rd_addr[p]]);
      drainScoreboard();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
